// File: rtl/seq_det_pkg.sv
// Shared limits and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam int unsigned PAT_LEN_MIN = 2;
    localparam int unsigned PAT_LEN_MAX = 16;
    localparam int unsigned CNT_W_MIN   = 1;
    localparam int unsigned CNT_W_MAX   = 16;

    function automatic int unsigned min_sat(input int unsigned val, input int unsigned lim);
        return (val > lim) ? lim : val;
    endfunction

    function automatic bit params_legal(input int unsigned pat_len, input int unsigned cnt_w);
        return (pat_len >= PAT_LEN_MIN) && (pat_len <= PAT_LEN_MAX) &&
               (cnt_w >= CNT_W_MIN) && (cnt_w <= CNT_W_MAX);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);

    logic [W-1:0] cnt_q, cnt_d;

    assign sat = (cnt_q == '1);
    assign q   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector: pulses F the cycle after the last PAT_LEN sampled bits equal the pattern.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned          PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1101,
    parameter bit                   OVERLAP = 1'b1,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic               I,
    input  logic               clear,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    output logic               F,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam int unsigned HIST_W = PAT_LEN - 1;
    localparam int unsigned FILL_W = $clog2(PAT_LEN);
    localparam int unsigned FULL   = PAT_LEN - 1;
    // An illegal parameterisation simply never reports a match.
    localparam bit          PARAMS_OK = params_legal(PAT_LEN, CNT_W);

    logic [HIST_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PAT_LEN-1:0] pat_q,  pat_d;
    logic               f_q,    f_d;
    logic [PAT_LEN-1:0] cand;
    logic               hit;
    logic               cnt_inc;

    // Next-state: clear beats pat_load beats en; idle edges only drop F.
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        f_d     = 1'b0;
        cnt_inc = 1'b0;
        cand    = {hist_q, I};
        hit     = PARAMS_OK && (fill_q == FILL_W'(FULL)) && (cand == pat_q);

        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            f_d     = hit;
            cnt_inc = hit;
            hist_d  = cand[HIST_W-1:0];
            if (hit && !OVERLAP) begin
                fill_d = '0;
            end else begin
                fill_d = FILL_W'(min_sat(32'(fill_q) + 32'd1, FULL));
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PATTERN;
            f_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            f_q    <= f_d;
        end
    end

    assign F = f_q;

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (clear),
        .inc   (cnt_inc),
        .q     (match_count),
        .sat   (count_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: default, non-overlap and 2-bit-counter/1111 instances on shared stimulus.
module tb_seq_detector_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       en, din, clr, ld;
    logic [3:0] pin;

    logic [2:0] f;
    logic [2:0] sat;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    seq_detector_param u_a (
        .clock(clock), .reset(reset), .en(en), .I(din), .clear(clr), .pat_load(ld),
        .pat_in(pin), .F(f[0]), .match_count(cnt_a), .count_sat(sat[0])
    );

    seq_detector_param #(.OVERLAP(1'b0)) u_b (
        .clock(clock), .reset(reset), .en(en), .I(din), .clear(clr), .pat_load(ld),
        .pat_in(pin), .F(f[1]), .match_count(cnt_b), .count_sat(sat[1])
    );

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u_c (
        .clock(clock), .reset(reset), .en(en), .I(din), .clear(clr), .pat_load(ld),
        .pat_in(pin), .F(f[2]), .match_count(cnt_c), .count_sat(sat[2])
    );

    // Reference model: unbounded bit window plus count of bits seen since the last restart.
    typedef struct {
        logic [2:0] f;
        int         c0;
        int         c1;
        int         c2;
    } exp_t;

    exp_t        sbq[$];
    int          m_nb  [3];
    logic [31:0] m_win [3];
    logic [3:0]  m_pat [3];
    int          m_cnt [3];

    function automatic logic [3:0] init_pat(input int k);
        return (k == 2) ? 4'b1111 : 4'b1101;
    endfunction

    function automatic bit ovl(input int k);
        return k != 1;
    endfunction

    function automatic int cmax(input int k);
        return (k == 2) ? 3 : 255;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_nb[k]  = 0;
            m_win[k] = '0;
            m_pat[k] = init_pat(k);
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_step(input logic e, input logic b, input logic c, input logic l,
                              input logic [3:0] p);
        exp_t x;
        bit   hit;
        for (int k = 0; k < 3; k++) begin
            x.f[k] = 1'b0;
            if (c) begin
                m_nb[k]  = 0;
                m_cnt[k] = 0;
            end else if (l) begin
                m_pat[k] = p;
                m_nb[k]  = 0;
            end else if (e) begin
                m_win[k] = {m_win[k][30:0], b};
                m_nb[k]  = m_nb[k] + 1;
                hit      = (m_nb[k] >= 4) && (m_win[k][3:0] == m_pat[k]);
                x.f[k]   = hit;
                if (hit) begin
                    if (m_cnt[k] < cmax(k)) m_cnt[k] = m_cnt[k] + 1;
                    if (!ovl(k)) m_nb[k] = 0;
                end
            end
        end
        x.c0 = m_cnt[0];
        x.c1 = m_cnt[1];
        x.c2 = m_cnt[2];
        sbq.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle, let the edge happen, then compare all instances against the scoreboard.
    task automatic step(input logic e, input logic b, input logic c, input logic l,
                        input logic [3:0] p, input string tag);
        exp_t x;
        en = e; din = b; clr = c; ld = l; pin = p;
        model_step(e, b, c, l, p);
        @(posedge clock);
        #1;
        x = sbq.pop_front();
        check({tag, "_fa"}, 32'(f[0]), 32'(x.f[0]));
        check({tag, "_fb"}, 32'(f[1]), 32'(x.f[1]));
        check({tag, "_fc"}, 32'(f[2]), 32'(x.f[2]));
        check({tag, "_ca"}, 32'(cnt_a), x.c0);
        check({tag, "_cb"}, 32'(cnt_b), x.c1);
        check({tag, "_cc"}, 32'(cnt_c), x.c2);
        check({tag, "_sa"}, 32'(sat[0]), 32'(x.c0 == 255));
        check({tag, "_sb"}, 32'(sat[1]), 32'(x.c1 == 255));
        check({tag, "_sc"}, 32'(sat[2]), 32'(x.c2 == 3));
    endtask

    // Hand-derived vectors for the default instance (pattern 1101, overlap on).
    typedef struct {
        logic       en;
        logic       i;
        logic       clr;
        logic       ld;
        logic [3:0] pin;
        logic       ef;
        int         ec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic b, input logic c, input logic l,
                       input logic [3:0] p, input logic ef, input int ec);
        vec_t v;
        v.en = e; v.i = b; v.clr = c; v.ld = l; v.pin = p; v.ef = ef; v.ec = ec;
        tbl.push_back(v);
    endtask

    initial begin
        int hits_c;

        // T1 overlap: 1,1,0,1,1,0,1
        add(1, 1, 0, 0, 4'h0, 0, 0);
        add(1, 1, 0, 0, 4'h0, 0, 0);
        add(1, 0, 0, 0, 4'h0, 0, 0);
        add(1, 1, 0, 0, 4'h0, 1, 1);
        add(1, 1, 0, 0, 4'h0, 0, 1);
        add(1, 0, 0, 0, 4'h0, 0, 1);
        add(1, 1, 0, 0, 4'h0, 1, 2);
        // clear and pat_load together: clear wins, pattern stays 1101
        add(1, 1, 1, 1, 4'b0000, 0, 0);
        // T6: 1,1,0, three idle cycles, then 1
        add(1, 1, 0, 0, 4'h0, 0, 0);
        add(1, 1, 0, 0, 4'h0, 0, 0);
        add(1, 0, 0, 0, 4'h0, 0, 0);
        add(0, 1, 0, 0, 4'h0, 0, 0);
        add(0, 0, 0, 0, 4'h0, 0, 0);
        add(0, 1, 0, 0, 4'h0, 0, 0);
        add(1, 1, 0, 0, 4'h0, 1, 1);
        // T4: load 0110, detect it; count kept across the load
        add(1, 1, 0, 1, 4'b0110, 0, 1);
        add(1, 0, 0, 0, 4'h0, 0, 1);
        add(1, 1, 0, 0, 4'h0, 0, 1);
        add(1, 1, 0, 0, 4'h0, 0, 1);
        add(1, 0, 0, 0, 4'h0, 1, 2);
        // reload 0110 to restart history; old pattern 1101 must not fire
        add(0, 0, 0, 1, 4'b0110, 0, 2);
        add(1, 1, 0, 0, 4'h0, 0, 2);
        add(1, 1, 0, 0, 4'h0, 0, 2);
        add(1, 0, 0, 0, 4'h0, 0, 2);
        add(1, 1, 0, 0, 4'h0, 0, 2);

        en = 0; din = 0; clr = 0; ld = 0; pin = '0;
        reset = 1'b1;
        model_reset();
        #2 reset = 1'b0;
        #10;
        check("rst_f",   32'(f),     32'd0);
        check("rst_ca",  32'(cnt_a), 32'd0);
        check("rst_cb",  32'(cnt_b), 32'd0);
        check("rst_cc",  32'(cnt_c), 32'd0);
        check("rst_sat", 32'(sat),   32'd0);
        @(negedge clock);
        reset = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].i, tbl[i].clr, tbl[i].ld, tbl[i].pin, $sformatf("v%0d", i));
            check($sformatf("v%0d_tbl_f", i),   32'(f[0]),  32'(tbl[i].ef));
            check($sformatf("v%0d_tbl_cnt", i), 32'(cnt_a), tbl[i].ec);
            if (i == 6) begin
                check("t2_cnt_nonoverlap", 32'(cnt_b), 32'd1);
            end
        end

        // T5: reset mid-stream after 1,1,0 (pattern is 0110 at this point)
        step(1, 1, 0, 0, 4'h0, "t5a");
        step(1, 1, 0, 0, 4'h0, "t5b");
        step(1, 0, 0, 0, 4'h0, "t5c");
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("t5_async_f",   32'(f),     32'd0);
        check("t5_async_ca",  32'(cnt_a), 32'd0);
        check("t5_async_cb",  32'(cnt_b), 32'd0);
        check("t5_async_sat", 32'(sat),   32'd0);
        @(negedge clock);
        reset = 1'b1;
        step(1, 1, 0, 0, 4'h0, "t5d");
        check("t5_no_early_f", 32'(f[0]), 32'd0);
        step(1, 1, 0, 0, 4'h0, "t5e");
        step(1, 1, 0, 0, 4'h0, "t5f");
        step(1, 0, 0, 0, 4'h0, "t5g");
        step(1, 1, 0, 0, 4'h0, "t5h");
        check("t5_f",   32'(f[0]),  32'd1);
        check("t5_cnt", 32'(cnt_a), 32'd1);

        // T3: seven 1s into the 1111 / 2-bit-counter instance
        step(0, 0, 1, 0, 4'h0, "t3clr");
        hits_c = 0;
        for (int k = 0; k < 7; k++) begin
            step(1, 1, 0, 0, 4'h0, $sformatf("t3b%0d", k));
            if (f[2]) hits_c++;
        end
        check("t3_hits",    32'(hits_c), 32'd4);
        check("t3_cnt_sat", 32'(cnt_c),  32'd3);
        check("t3_sat",     32'(sat[2]), 32'd1);
        step(0, 1, 0, 0, 4'h0, "t3idle0");
        step(0, 1, 0, 0, 4'h0, "t3idle1");
        check("t3_sat_held", 32'(sat[2]), 32'd1);
        check("t3_f_idle",   32'(f[2]),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
